// File: rtl/csr_trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_ctrl_if
// Purpose  : Groups the request channel from decode/execute and the CSR-file
//            channel of csr_trap_ctrl into one bundle.
// Modports : master - the csr_trap_ctrl side (takes requests, drives the CSR file)
//            slave  - the environment side (offers requests, models the CSR file)
// Signals  : req_*            request handshake and captured instruction fields
//            priv_mode        current privilege level
//            csr_addr/rdata   CSR read port (rdata is combinational)
//            wr1_addr/data1_in/wcsr_n   CSR write port, active-low strobe
//            exceptionFromInst/mret/mepc_in/mtval_in/mcause_in  trap interface
//            resp_*           rd result,  redirect_*  PC redirect
// Revision : 1.0 - initial release
// ============================================================================
interface csr_trap_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [11:0] req_csr;
   logic [4:0]  req_rs1_idx;
   logic [31:0] req_rs1_data;
   logic [31:0] req_pc;
   logic [31:0] req_inst;
   logic [1:0]  priv_mode;
   logic [11:0] csr_addr;
   logic [31:0] csr_rdata;
   logic [11:0] wr1_addr;
   logic [31:0] data1_in;
   logic        wcsr_n;
   logic        exceptionFromInst;
   logic        mret;
   logic [31:0] mepc_in;
   logic [31:0] mtval_in;
   logic [3:0]  mcause_in;
   logic        resp_valid;
   logic [31:0] resp_rd_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      input  req_valid, req_funct3, req_csr, req_rs1_idx, req_rs1_data,
             req_pc, req_inst, priv_mode, csr_rdata,
      output req_ready, csr_addr, wr1_addr, data1_in, wcsr_n,
             exceptionFromInst, mret, mepc_in, mtval_in, mcause_in,
             resp_valid, resp_rd_data, redirect_valid, redirect_pc
   );

   modport slave (
      output req_valid, req_funct3, req_csr, req_rs1_idx, req_rs1_data,
             req_pc, req_inst, priv_mode, csr_rdata,
      input  req_ready, csr_addr, wr1_addr, data1_in, wcsr_n,
             exceptionFromInst, mret, mepc_in, mtval_in, mcause_in,
             resp_valid, resp_rd_data, redirect_valid, redirect_pc
   );
endinterface
`default_nettype wire

// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_ctrl
// Purpose  : Initiator side of the machine-mode CSR file. Runs Zicsr ops as
//            read-modify-write sequences, raises traps for illegal/ECALL/
//            EBREAK, handles MRET, and reads mtvec/mepc to redirect fetch.
// Ports    : clk      - clock, all state changes on posedge
//            reset_x  - asynchronous active-low reset
//            bus      - csr_trap_ctrl_if.master (request + CSR-file channels)
// Params   : MTVEC_ADDR - CSR read for the trap target
//            MEPC_ADDR  - CSR read for the MRET target
// Revision : 1.0 - initial release
// ============================================================================
module csr_trap_ctrl #(
   parameter logic [11:0] MTVEC_ADDR = 12'h305,
   parameter logic [11:0] MEPC_ADDR  = 12'h341
) (
   input  wire logic         clk,
   input  wire logic         reset_x,
   csr_trap_ctrl_if.master   bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WRITE = 3'd2,
      S_TRAP  = 3'd3,
      S_VEC   = 3'd4,
      S_RET   = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [1:0]  r_op;        // funct3[1:0]: 01 RW, 10 RS, 11 RC
   logic [11:0] r_csr;
   logic [31:0] r_src;
   logic        r_wr;
   logic        r_is_csr;    // 1: DONE answers on resp, 0: DONE redirects
   logic [31:0] r_pc;
   logic [3:0]  r_cause;
   logic [31:0] r_tval;
   logic [31:0] r_old;
   logic [31:0] r_target;

   // ---------------- request decode (valid only during capture) ----------
   logic        w_xfer;
   logic        w_sys;
   logic        w_ecall;
   logic        w_ebreak;
   logic        w_mret_sel;
   logic        w_writes;
   logic        w_csr_ok;
   logic        w_illegal;
   logic [31:0] w_src;
   logic [31:0] w_new;

   assign w_xfer     = bus.req_valid && (r_state == S_IDLE);
   assign w_sys      = (bus.req_funct3 == 3'b000);
   assign w_ecall    = w_sys && (bus.req_csr == 12'h000);
   assign w_ebreak   = w_sys && (bus.req_csr == 12'h001);
   assign w_mret_sel = w_sys && (bus.req_csr == 12'h302);
   // RS/RC with rs1 = x0 (or zimm = 0) only read; RW always writes.
   assign w_writes   = (bus.req_funct3[1:0] == 2'b01) || (bus.req_rs1_idx != 5'd0);
   assign w_csr_ok   = (bus.req_csr == 12'h300) || (bus.req_csr == 12'h304) ||
                       (bus.req_csr == 12'h305) ||
                       ((bus.req_csr >= 12'h340) && (bus.req_csr <= 12'h344));
   assign w_illegal  = (bus.req_funct3 == 3'b100) ||
                       (w_sys && !(w_ecall || w_ebreak || w_mret_sel)) ||
                       (w_mret_sel && (bus.priv_mode != 2'b11)) ||
                       (!w_sys && (!w_csr_ok ||
                                   (bus.req_csr[9:8] > bus.priv_mode) ||
                                   ((bus.req_csr[11:10] == 2'b11) && w_writes)));
   assign w_src      = bus.req_funct3[2] ? {27'b0, bus.req_rs1_idx} : bus.req_rs1_data;

   always_comb begin
      w_new = r_src;
      case (r_op)
         2'b10:   w_new = r_old | r_src;
         2'b11:   w_new = r_old & ~r_src;
         default: w_new = r_src;
      endcase
   end

   // ---------------- state register + captured request ------------------
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_state  <= S_IDLE;
         r_op     <= 2'b00;
         r_csr    <= 12'h000;
         r_src    <= 32'h0;
         r_wr     <= 1'b0;
         r_is_csr <= 1'b0;
         r_pc     <= 32'h0;
         r_cause  <= 4'h0;
         r_tval   <= 32'h0;
         r_old    <= 32'h0;
         r_target <= 32'h0;
      end else begin
         r_state <= w_next;
         if (w_xfer) begin
            r_op     <= bus.req_funct3[1:0];
            r_csr    <= bus.req_csr;
            r_src    <= w_src;
            r_wr     <= w_writes;
            r_is_csr <= !w_illegal && !w_sys;
            r_pc     <= bus.req_pc;
            if (w_illegal) begin
               r_cause <= 4'd2;
               r_tval  <= bus.req_inst;
            end else if (w_ebreak) begin
               r_cause <= 4'd3;
               r_tval  <= bus.req_pc;
            end else begin
               r_cause <= (bus.priv_mode == 2'b11) ? 4'd11 : 4'd8;
               r_tval  <= 32'h0;
            end
         end
         if (r_state == S_READ) r_old    <= bus.csr_rdata;
         if (r_state == S_VEC)  r_target <= {bus.csr_rdata[31:2], 2'b00};
         if (r_state == S_RET)  r_target <= bus.csr_rdata;
      end
   end

   // ---------------- next state and decoded outputs ----------------------
   always_comb begin
      w_next                = r_state;
      bus.req_ready         = 1'b0;
      bus.csr_addr          = 12'h000;
      bus.wr1_addr          = 12'h000;
      bus.data1_in          = 32'h0;
      bus.wcsr_n            = 1'b1;
      bus.exceptionFromInst = 1'b0;
      bus.mret              = 1'b0;
      bus.mepc_in           = 32'h0;
      bus.mtval_in          = 32'h0;
      bus.mcause_in         = 4'h0;
      bus.resp_valid        = 1'b0;
      bus.resp_rd_data      = 32'h0;
      bus.redirect_valid    = 1'b0;
      bus.redirect_pc       = 32'h0;
      case (r_state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (w_illegal || w_ecall || w_ebreak) w_next = S_TRAP;
               else if (w_mret_sel)                  w_next = S_RET;
               else                                  w_next = S_READ;
            end
         end
         S_READ: begin
            bus.csr_addr = r_csr;
            w_next       = r_wr ? S_WRITE : S_DONE;
         end
         S_WRITE: begin
            bus.wcsr_n   = 1'b0;
            bus.wr1_addr = r_csr;
            bus.data1_in = w_new;
            w_next       = S_DONE;
         end
         S_TRAP: begin
            bus.exceptionFromInst = 1'b1;
            bus.mepc_in           = r_pc;
            bus.mtval_in          = r_tval;
            bus.mcause_in         = r_cause;
            w_next                = S_VEC;
         end
         S_VEC: begin
            bus.csr_addr = MTVEC_ADDR;
            w_next       = S_DONE;
         end
         S_RET: begin
            bus.mret     = 1'b1;
            bus.csr_addr = MEPC_ADDR;
            w_next       = S_DONE;
         end
         S_DONE: begin
            if (r_is_csr) begin
               bus.resp_valid   = 1'b1;
               bus.resp_rd_data = r_old;
            end else begin
               bus.redirect_valid = 1'b1;
               bus.redirect_pc    = r_target;
            end
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_trap_ctrl
// Purpose  : Directed self-checking bench for csr_trap_ctrl. A tiny CSR-file
//            model returns fixed contents for mstatus/mtvec/mscratch/mepc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_trap_ctrl;
   logic clk;
   logic reset_x;
   int   total;
   int   bad;

   logic [31:0] m_mstatus;
   logic [31:0] m_mtvec;
   logic [31:0] m_mscratch;
   logic [31:0] m_mepc;

   csr_trap_ctrl_if bus ();

   csr_trap_ctrl #(.MTVEC_ADDR(12'h305), .MEPC_ADDR(12'h341)) dut (
      .clk     (clk),
      .reset_x (reset_x),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      bus.csr_rdata = 32'h0;
      case (bus.csr_addr)
         12'h300: bus.csr_rdata = m_mstatus;
         12'h305: bus.csr_rdata = m_mtvec;
         12'h340: bus.csr_rdata = m_mscratch;
         12'h341: bus.csr_rdata = m_mepc;
         default: bus.csr_rdata = 32'h0;
      endcase
   end

   // Offer one request for one clock; returns #1 after the transfer edge (T+1).
   task automatic drive(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] idx,
                        input logic [31:0] d, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [1:0] priv);
      bus.req_funct3   = f3;
      bus.req_csr      = csr;
      bus.req_rs1_idx  = idx;
      bus.req_rs1_data = d;
      bus.req_pc       = pc;
      bus.req_inst     = inst;
      bus.priv_mode    = priv;
      bus.req_valid    = 1'b1;
      @(posedge clk); #1;
      bus.req_valid    = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_x = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.req_ready !== 1'b1)          begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
      total++; if (bus.wcsr_n !== 1'b1)             begin bad++; $display("FAIL rst_wcsr_n got=%b exp=1", bus.wcsr_n); end
      total++; if (bus.exceptionFromInst !== 1'b0)  begin bad++; $display("FAIL rst_exc got=%b exp=0", bus.exceptionFromInst); end
      total++; if (bus.mret !== 1'b0)               begin bad++; $display("FAIL rst_mret got=%b exp=0", bus.mret); end
      total++; if (bus.resp_valid !== 1'b0)         begin bad++; $display("FAIL rst_resp got=%b exp=0", bus.resp_valid); end
      total++; if (bus.redirect_valid !== 1'b0)     begin bad++; $display("FAIL rst_redir got=%b exp=0", bus.redirect_valid); end
      total++; if (bus.csr_addr !== 12'h0)          begin bad++; $display("FAIL rst_csr_addr got=%h exp=0", bus.csr_addr); end
      total++; if (bus.data1_in !== 32'h0)          begin bad++; $display("FAIL rst_data1 got=%h exp=0", bus.data1_in); end
      total++; if (bus.redirect_pc !== 32'h0)       begin bad++; $display("FAIL rst_redir_pc got=%h exp=0", bus.redirect_pc); end
      @(negedge clk);
      reset_x = 1'b1;
   endtask

   task automatic test_csrrw();
      m_mscratch = 32'h0802_0000;
      drive(3'b001, 12'h340, 5'd5, 32'hA5A5_0000, 32'h0000_0010, 32'h3402_92F3, 2'b11);
      total++; if (bus.csr_addr !== 12'h340) begin bad++; $display("FAIL rw_read_addr got=%h exp=340", bus.csr_addr); end
      total++; if (bus.req_ready !== 1'b0)   begin bad++; $display("FAIL rw_busy got=%b exp=0", bus.req_ready); end
      step(); // T+2
      total++; if (bus.wcsr_n !== 1'b0)               begin bad++; $display("FAIL rw_wcsr_n got=%b exp=0", bus.wcsr_n); end
      total++; if (bus.wr1_addr !== 12'h340)          begin bad++; $display("FAIL rw_wr_addr got=%h exp=340", bus.wr1_addr); end
      total++; if (bus.data1_in !== 32'hA5A5_0000)    begin bad++; $display("FAIL rw_data got=%h exp=a5a50000", bus.data1_in); end
      total++; if (bus.resp_valid !== 1'b0)           begin bad++; $display("FAIL rw_early_resp got=%b exp=0", bus.resp_valid); end
      step(); // T+3
      total++; if (bus.resp_valid !== 1'b1)           begin bad++; $display("FAIL rw_resp got=%b exp=1", bus.resp_valid); end
      total++; if (bus.resp_rd_data !== 32'h0802_0000) begin bad++; $display("FAIL rw_rd got=%h exp=08020000", bus.resp_rd_data); end
      total++; if (bus.wcsr_n !== 1'b1)               begin bad++; $display("FAIL rw_wcsr_after got=%b exp=1", bus.wcsr_n); end
      step(); // T+4
      total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rw_idle got=%b/%b exp=1/0", bus.req_ready, bus.resp_valid); end
   endtask

   task automatic test_csrrs_nowrite();
      m_mstatus = 32'h0000_0008;
      drive(3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 32'h0000_0014, 32'h3000_2573, 2'b11);
      total++; if (bus.wcsr_n !== 1'b1) begin bad++; $display("FAIL rs_no_write1 got=%b exp=1", bus.wcsr_n); end
      step(); // T+2
      total++; if (bus.resp_valid !== 1'b1)            begin bad++; $display("FAIL rs_resp got=%b exp=1", bus.resp_valid); end
      total++; if (bus.resp_rd_data !== 32'h0000_0008) begin bad++; $display("FAIL rs_rd got=%h exp=00000008", bus.resp_rd_data); end
      total++; if (bus.wcsr_n !== 1'b1)                begin bad++; $display("FAIL rs_no_write2 got=%b exp=1", bus.wcsr_n); end
      step();
      // CSRRCI 300, zimm=8: 8 & ~8 = 0; rs1_data must be ignored
      drive(3'b111, 12'h300, 5'd8, 32'hDEAD_BEEF, 32'h0000_0018, 32'h3004_7573, 2'b11);
      step(); // T+2
      total++; if (bus.wcsr_n !== 1'b0)     begin bad++; $display("FAIL rci_wcsr_n got=%b exp=0", bus.wcsr_n); end
      total++; if (bus.data1_in !== 32'h0)  begin bad++; $display("FAIL rci_data got=%h exp=0", bus.data1_in); end
      step(); // T+3
      total++; if (bus.resp_rd_data !== 32'h8 || bus.resp_valid !== 1'b1) begin bad++; $display("FAIL rci_resp got=%h/%b exp=8/1", bus.resp_rd_data, bus.resp_valid); end
      step();
      // CSRRSI 304 zimm=3 with old=0 (model returns 0): new = 3
      drive(3'b110, 12'h304, 5'd3, 32'h0, 32'h0000_001C, 32'h3041_E073, 2'b11);
      step();
      total++; if (bus.data1_in !== 32'h3 || bus.wr1_addr !== 12'h304) begin bad++; $display("FAIL rsi_data got=%h@%h exp=3@304", bus.data1_in, bus.wr1_addr); end
      repeat (2) step();
   endtask

   task automatic test_illegal_u();
      m_mtvec = 32'h0000_0103;
      drive(3'b001, 12'h305, 5'd3, 32'h1234_5678, 32'h0000_0200, 32'h3051_9173, 2'b00);
      total++; if (bus.exceptionFromInst !== 1'b1)  begin bad++; $display("FAIL ill_exc got=%b exp=1", bus.exceptionFromInst); end
      total++; if (bus.mcause_in !== 4'd2)          begin bad++; $display("FAIL ill_cause got=%0d exp=2", bus.mcause_in); end
      total++; if (bus.mtval_in !== 32'h3051_9173)  begin bad++; $display("FAIL ill_tval got=%h exp=30519173", bus.mtval_in); end
      total++; if (bus.mepc_in !== 32'h0000_0200)   begin bad++; $display("FAIL ill_mepc got=%h exp=00000200", bus.mepc_in); end
      total++; if (bus.wcsr_n !== 1'b1)             begin bad++; $display("FAIL ill_wcsr got=%b exp=1", bus.wcsr_n); end
      step(); // T+2
      total++; if (bus.exceptionFromInst !== 1'b0 || bus.csr_addr !== 12'h305) begin bad++; $display("FAIL ill_vec got=%b/%h exp=0/305", bus.exceptionFromInst, bus.csr_addr); end
      step(); // T+3
      total++; if (bus.redirect_valid !== 1'b1)        begin bad++; $display("FAIL ill_redir got=%b exp=1", bus.redirect_valid); end
      total++; if (bus.redirect_pc !== 32'h0000_0100)  begin bad++; $display("FAIL ill_redir_pc got=%h exp=00000100", bus.redirect_pc); end
      total++; if (bus.resp_valid !== 1'b0)            begin bad++; $display("FAIL ill_no_resp got=%b exp=0", bus.resp_valid); end
      step();
   endtask

   task automatic test_ecall_ebreak();
      drive(3'b000, 12'h000, 5'd0, 32'h0, 32'h0000_0040, 32'h0000_0073, 2'b00);
      total++; if (bus.mcause_in !== 4'd8 || bus.mepc_in !== 32'h40 || bus.mtval_in !== 32'h0) begin bad++; $display("FAIL ecall_u got=%0d/%h/%h exp=8/40/0", bus.mcause_in, bus.mepc_in, bus.mtval_in); end
      repeat (3) step();
      drive(3'b000, 12'h000, 5'd0, 32'h0, 32'h0000_0060, 32'h0000_0073, 2'b11);
      total++; if (bus.mcause_in !== 4'd11 || bus.exceptionFromInst !== 1'b1) begin bad++; $display("FAIL ecall_m got=%0d/%b exp=11/1", bus.mcause_in, bus.exceptionFromInst); end
      repeat (3) step();
      drive(3'b000, 12'h001, 5'd0, 32'h0, 32'h0000_0080, 32'h0010_0073, 2'b11);
      total++; if (bus.mcause_in !== 4'd3 || bus.mtval_in !== 32'h80) begin bad++; $display("FAIL ebreak got=%0d/%h exp=3/80", bus.mcause_in, bus.mtval_in); end
      repeat (3) step();
      // unknown SYSTEM selector is illegal
      drive(3'b000, 12'h105, 5'd0, 32'h0, 32'h0000_0090, 32'h1050_0073, 2'b11);
      total++; if (bus.mcause_in !== 4'd2 || bus.mtval_in !== 32'h1050_0073) begin bad++; $display("FAIL sys_bad got=%0d/%h exp=2/10500073", bus.mcause_in, bus.mtval_in); end
      repeat (3) step();
      // funct3=100 is illegal even in M mode
      drive(3'b100, 12'h340, 5'd1, 32'h0, 32'h0000_00A0, 32'h3400_C073, 2'b11);
      total++; if (bus.mcause_in !== 4'd2 || bus.exceptionFromInst !== 1'b1) begin bad++; $display("FAIL f3_100 got=%0d/%b exp=2/1", bus.mcause_in, bus.exceptionFromInst); end
      repeat (3) step();
   endtask

   task automatic test_mret();
      m_mepc = 32'h0000_0044;
      drive(3'b000, 12'h302, 5'd0, 32'h0, 32'h0000_00B0, 32'h3020_0073, 2'b11);
      total++; if (bus.mret !== 1'b1 || bus.exceptionFromInst !== 1'b0) begin bad++; $display("FAIL mret_pulse got=%b/%b exp=1/0", bus.mret, bus.exceptionFromInst); end
      total++; if (bus.csr_addr !== 12'h341) begin bad++; $display("FAIL mret_addr got=%h exp=341", bus.csr_addr); end
      step(); // T+2
      total++; if (bus.mret !== 1'b0 || bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL mret_redir got=%b/%b exp=0/1", bus.mret, bus.redirect_valid); end
      total++; if (bus.redirect_pc !== 32'h0000_0044) begin bad++; $display("FAIL mret_pc got=%h exp=00000044", bus.redirect_pc); end
      step();
      drive(3'b000, 12'h302, 5'd0, 32'h0, 32'h0000_00C0, 32'h3020_0073, 2'b00);
      total++; if (bus.mret !== 1'b0 || bus.exceptionFromInst !== 1'b1 || bus.mcause_in !== 4'd2) begin bad++; $display("FAIL mret_u got=%b/%b/%0d exp=0/1/2", bus.mret, bus.exceptionFromInst, bus.mcause_in); end
      repeat (3) step();
   endtask

   task automatic test_reset_mid();
      drive(3'b001, 12'h340, 5'd5, 32'h1111_2222, 32'h0000_00D0, 32'h3402_92F3, 2'b11);
      step(); // T+2: WRITE
      total++; if (bus.wcsr_n !== 1'b0) begin bad++; $display("FAIL mid_pre got=%b exp=0", bus.wcsr_n); end
      reset_x = 1'b0;
      #1;
      total++; if (bus.wcsr_n !== 1'b1 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL mid_async got=%b/%b exp=1/1", bus.wcsr_n, bus.req_ready); end
      @(negedge clk);
      reset_x = 1'b1;
      step();
      total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL mid_no_pulse got=%b/%b exp=0/1", bus.resp_valid, bus.req_ready); end
   endtask

   task automatic test_back_to_back();
      int n;
      bus.req_funct3   = 3'b010;
      bus.req_csr      = 12'h300;
      bus.req_rs1_idx  = 5'd0;
      bus.req_rs1_data = 32'h0;
      bus.req_pc       = 32'h0000_00E0;
      bus.req_inst     = 32'h3000_2573;
      bus.priv_mode    = 2'b11;
      bus.req_valid    = 1'b1;
      step(); // T+1
      total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", bus.req_ready); end
      step(); // T+2
      total++; if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin bad++; $display("FAIL b2b_first got=%b/%b exp=1/0", bus.resp_valid, bus.req_ready); end
      step(); // T+3: back in IDLE, second request accepted here
      total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b/%b exp=1/0", bus.req_ready, bus.resp_valid); end
      n = 0;
      while (bus.resp_valid !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      bus.req_valid = 1'b0;
      total++; if (n !== 2) begin bad++; $display("FAIL b2b_second got=%0d exp=2 cycles", n); end
      step();
      total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b/%b exp=1/0", bus.req_ready, bus.resp_valid); end
   endtask

   initial begin
      total            = 0;
      bad              = 0;
      m_mstatus        = 32'h0;
      m_mtvec          = 32'h0;
      m_mscratch       = 32'h0;
      m_mepc           = 32'h0;
      bus.req_valid    = 1'b0;
      bus.req_funct3   = 3'b0;
      bus.req_csr      = 12'h0;
      bus.req_rs1_idx  = 5'd0;
      bus.req_rs1_data = 32'h0;
      bus.req_pc       = 32'h0;
      bus.req_inst     = 32'h0;
      bus.priv_mode    = 2'b11;
      test_reset();
      step();
      test_csrrw();
      test_csrrs_nowrite();
      test_illegal_u();
      test_ecall_ebreak();
      test_mret();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
